// File: rtl/pl_ifetch_if.sv
// Fetch-stage bus: combinational instruction-memory port, redirect request
// and the decode-side valid/ready head-of-queue handshake.
interface pl_ifetch_if;
    logic [31:0] imem_a;
    logic [31:0] imem_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        d_ready;
    logic        d_valid;
    logic [31:0] d_inst;
    logic [31:0] d_pc;
    logic [31:0] d_pc4;

    modport master (
        output imem_a, d_valid, d_inst, d_pc, d_pc4,
        input  imem_inst, redirect, redirect_pc, d_ready
    );

    modport slave (
        input  imem_a, d_valid, d_inst, d_pc, d_pc4,
        output imem_inst, redirect, redirect_pc, d_ready
    );
endinterface

// File: rtl/pl_ifetch.sv
// Pipelined instruction fetch: PC register feeding a 2-entry {pc, inst} FIFO.
// Define IFETCH_PERF_EN to add perf_fetch/perf_flush event counters.
module pl_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    pl_ifetch_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_flush
`endif
);

    logic [31:0] pc_reg, pc_next;
    logic [1:0]  count_reg, count_next;
    logic        head_reg, head_next;
    logic [31:0] ent_pc_reg   [2];
    logic [31:0] ent_inst_reg [2];
    logic        pop, push, tail;
    logic        unused_ok;

    assign unused_ok = ^bus.redirect_pc[1:0];

    always_comb begin
        pop        = (count_reg != 2'd0) && bus.d_ready;
        push       = !bus.redirect && ((count_reg != 2'd2) || pop);
        // Tail slot is head + count modulo 2; when full it aliases the head being popped.
        tail       = head_reg ^ count_reg[0];
        pc_next    = pc_reg;
        count_next = count_reg;
        head_next  = head_reg;
        if (bus.redirect) begin
            pc_next    = {bus.redirect_pc[31:2], 2'b00};
            count_next = 2'd0;
            head_next  = 1'b0;
        end else begin
            if (push)
                pc_next = pc_reg + 32'd4;
            count_next = count_reg + {1'b0, push} - {1'b0, pop};
            head_next  = head_reg ^ pop;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc_reg    <= RESET_PC;
            count_reg <= 2'd0;
            head_reg  <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            count_reg <= count_next;
            head_reg  <= head_next;
        end
    end

    // Payload storage needs no reset: count gates every read.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (tail == 1'(gi))) begin
                    ent_pc_reg[gi]   <= pc_reg;
                    ent_inst_reg[gi] <= bus.imem_inst;
                end
            end
        end
    endgenerate

    logic [31:0] head_pc;
    assign head_pc     = ent_pc_reg[head_reg];
    assign bus.imem_a  = pc_reg;
    assign bus.d_valid = (count_reg != 2'd0);
    assign bus.d_pc    = head_pc;
    assign bus.d_inst  = ent_inst_reg[head_reg];
    assign bus.d_pc4   = head_pc + 32'd4;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_reg, perf_flush_reg;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            perf_fetch_reg <= 32'd0;
            perf_flush_reg <= 32'd0;
        end else begin
            if (push)
                perf_fetch_reg <= perf_fetch_reg + 32'd1;
            if (bus.redirect)
                perf_flush_reg <= perf_flush_reg + 32'd1;
        end
    end

    assign perf_fetch = perf_fetch_reg;
    assign perf_flush = perf_flush_reg;
`endif

endmodule

// File: tb/tb_pl_ifetch.sv
// Randomized bench for pl_ifetch against a queue-based fetch model.
// Define IFETCH_PERF_EN to also check the performance counters.
module tb_pl_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    pl_ifetch_if bus ();

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch, perf_flush;
    pl_ifetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .clrn(clrn), .bus(bus),
        .perf_fetch(perf_fetch), .perf_flush(perf_flush)
    );
`else
    pl_ifetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .clrn(clrn), .bus(bus)
    );
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:24], a[15:8], a[23:16]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.imem_inst = mem_word(bus.imem_a);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_fetch, m_flush;
    int          total = 0;
    int          passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_pc    = RESET_PC;
        m_fetch = 0;
        m_flush = 0;
    endtask

    // Called at posedge+2 with clrn high; pulses clrn low across one edge.
    task automatic do_reset();
        clrn = 1'b0;
        #1;
        check("rst_valid", 32'(bus.d_valid), 32'd0);
        check("rst_imem_a", bus.imem_a, RESET_PC);
`ifdef IFETCH_PERF_EN
        check("rst_perf_fetch", perf_fetch, 32'd0);
        check("rst_perf_flush", perf_flush, 32'd0);
`endif
        @(posedge clk);
        #2;
        clrn = 1'b1;
        model_reset();
        $display("reset: imem_a=%h", bus.imem_a);
    endtask

    // One cycle: drive inputs, check outputs against the model, clock, update model.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
        bit pop, push;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.d_ready     = rdy;
        #1;
        check("imem_a", bus.imem_a, m_pc);
        check("d_valid", 32'(bus.d_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("d_pc", bus.d_pc, q[0].pc);
            check("d_inst", bus.d_inst, q[0].inst);
            check("d_pc4", bus.d_pc4, q[0].pc + 32'd4);
        end
`ifdef IFETCH_PERF_EN
        check("perf_fetch", perf_fetch, m_fetch);
        check("perf_flush", perf_flush, m_flush);
`endif
        $display("cyc: rd=%b rpc=%h rdy=%b imem_a=%h v=%b d_pc=%h n=%0d",
                 rd, rpc, rdy, bus.imem_a, bus.d_valid, bus.d_pc, q.size());
        @(posedge clk);
        if (rd) begin
            q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
            m_flush++;
        end else begin
            pop  = (q.size() != 0) && rdy;
            push = (q.size() < 2) || pop;
            if (pop)
                void'(q.pop_front());
            if (push) begin
                q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
                m_fetch++;
            end
        end
        #2;
    endtask

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.d_ready     = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        clrn = 1'b1;
        model_reset();

        // Free-running stream with decode always ready
        for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1);

        // Backpressure saturates the queue, then drains in order
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0);
        check("sat_imem_a", bus.imem_a, 32'h08);
        check("sat_d_pc", bus.d_pc, 32'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);

        // Redirect with a full queue
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
        step(1'b1, 32'h2A, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        check("redir_d_pc", bus.d_pc, 32'h28);
        check("redir_d_pc4", bus.d_pc4, 32'h2C);

        // Redirect while the head is being consumed
        step(1'b0, 32'd0, 1'b0);
        step(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);

        // PC wrap at the top of the address space
        step(1'b1, 32'hFFFF_FFF6, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);

        // Asynchronous reset mid-stream with the queue full
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1);

`ifdef IFETCH_PERF_EN
        // Ten free-running cycles with one redirect
        do_reset();
        for (int i = 0; i < 10; i++)
            step(i == 4, 32'h40, 1'b1);
        check("perf10_fetch", perf_fetch, 32'd9);
        check("perf10_flush", perf_flush, 32'd1);
`endif

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic        rd;
            logic [31:0] rpc;
            rd  = ($urandom_range(0, 7) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                               : $urandom;
            if (i == 150)
                do_reset();
            step(rd, rpc, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pl_ifetch.md
PL_IFETCH -- requirements
Module: pl_ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1: single clock, all state rising-edge.
REQ-003 SHALL have port clrn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port imem_a, output, 32: byte address to the combinational instruction memory.
REQ-005 SHALL have port imem_inst, input, 32: instruction word returned for imem_a in the same cycle.
REQ-006 SHALL have port redirect, input, 1: branch/jump taken, flush and refetch.
REQ-007 SHALL have port redirect_pc, input, 32: new fetch address, valid when redirect=1.
REQ-008 SHALL have port d_ready, input, 1: decode stage accepts the head entry this cycle.
REQ-009 SHALL have port d_valid, output, 1: head entry valid.
REQ-010 SHALL have port d_inst, output, 32: head instruction.
REQ-011 SHALL have port d_pc, output, 32: head instruction address.
REQ-012 SHALL have port d_pc4, output, 32: d_pc + 4, modulo 2^32.

Function
REQ-013 SHALL hold a PC register and drive imem_a = PC combinationally.
REQ-014 SHALL hold a 2-entry FIFO of {pc, inst} with a 2-bit count (0..2).
REQ-015 SHALL push {PC, imem_inst} and set PC <= PC+4 when redirect=0 and (count<2 or pop occurs this cycle).
REQ-016 SHALL pop the head on d_valid & d_ready; d_valid = (count!=0), head outputs come straight from the FIFO with no extra register.
REQ-017 SHALL, on simultaneous push and pop, keep count unchanged and preserve order.
REQ-018 SHALL, when count=2 and no pop occurs, hold PC and perform no push.
REQ-019 SHALL, on redirect=1, empty the FIFO (count <= 0), set PC <= {redirect_pc[31:2],2'b00}, and perform no push; redirect has priority over push and pop.
REQ-020 SHALL treat a pop in a redirect cycle as completed by decode; the flush still discards all remaining entries.
REQ-021 SHALL produce d_valid=1 exactly one cycle after a push into an empty FIFO, giving 1-cycle fetch-to-decode latency.
REQ-022 SHALL let PC wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-023 SHALL drive d_inst, d_pc and d_pc4 as don't-care when d_valid=0; the bench SHALL NOT check them.

Reset
REQ-024 SHALL, on clrn=0 at any time, set PC=RESET_PC, count=0 and d_valid=0 immediately, without waiting for a clock edge.
REQ-025 SHALL perform the first push on the first rising edge with clrn=1, at address RESET_PC.

Configuration
REQ-026 SHALL, with IFETCH_PERF_EN defined, add output perf_fetch (32): number of pushes.
REQ-027 SHALL, with IFETCH_PERF_EN defined, add output perf_flush (32): number of redirect cycles.
REQ-028 SHALL reset both counters to 0 on clrn, and let them wrap modulo 2^32.
REQ-029 SHALL, without IFETCH_PERF_EN, omit both ports and counters, with all other behaviour identical.

Verification
REQ-030 Reset then d_ready=1 constant -> d_pc sequence 0x00,0x04,0x08,... one per cycle from cycle 1; imem_a=0x00 during cycle 0.
REQ-031 d_ready=0 for 5 cycles from reset -> count saturates at 2, imem_a holds 0x08, d_pc stays 0x00; d_ready=1 -> 0x00,0x04,0x08 delivered in order with no gap.
REQ-032 redirect=1, redirect_pc=0x2A with FIFO full -> next cycle d_valid=0, imem_a=0x28; following cycle d_pc=0x28, d_pc4=0x2C.
REQ-033 redirect asserted while d_valid=1 and d_ready=1 -> head consumed, no stale entry ever appears after the redirect.
REQ-034 clrn pulsed low mid-stream with count=2 -> d_valid=0 and imem_a=RESET_PC before the next clock edge; normal restart afterwards.
REQ-035 IFETCH_PERF_EN defined, 10 free-running cycles with one redirect -> perf_flush=1 and perf_fetch=9.
